// File: rtl/data_route_pkg.sv
// rtl/data_route_pkg.sv - shared constants and types for the data_route 1-to-2 distributor
package data_route_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;
  localparam int STAT_W    = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Encoded as {push, pop} so the FIFO can cast its strobes straight in.
  typedef enum logic [1:0] {
    FIFO_HOLD = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic int cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/route_fifo.sv
// rtl/route_fifo.sv - synchronous FIFO with registered count, one per data_route output port
module route_fifo
  import data_route_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_bits(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;
  fifo_op_e         op;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign op      = fifo_op_e'({do_push, do_pop});

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (op)
      FIFO_PUSH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      FIFO_POP: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
      FIFO_BOTH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/data_route.sv
// rtl/data_route.sv - 1-to-2 buffered router steering each input word to port A or B by in_sel
// Optional per-port transfer counters cnt_a/cnt_b when DATA_ROUTE_STATS_EN is defined.
module data_route
  import data_route_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [WIDTH-1:0]  in_data,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [WIDTH-1:0]  a_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [WIDTH-1:0]  b_data
`ifdef DATA_ROUTE_STATS_EN
  ,
  output logic [STAT_W-1:0] cnt_a,
  output logic [STAT_W-1:0] cnt_b
`endif
);

  logic push_a, push_b, pop_a, pop_b;
  logic full_a, full_b, empty_a, empty_b;

  // Only the selected FIFO's fullness matters: head-of-line blocking is intentional,
  // and consumer readiness never feeds back into in_ready.
  assign in_ready = (in_sel == SEL_B) ? !full_b : !full_a;
  assign push_a   = in_valid && in_ready && (in_sel == SEL_A);
  assign push_b   = in_valid && in_ready && (in_sel == SEL_B);

  assign a_valid = !empty_a;
  assign b_valid = !empty_b;
  assign pop_a   = a_valid && a_ready;
  assign pop_b   = b_valid && b_ready;

  route_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .CLK         (CLK),
    .RST         (RST),
    .push_i      (push_a),
    .push_data_i (in_data),
    .full_o      (full_a),
    .pop_i       (pop_a),
    .empty_o     (empty_a),
    .head_o      (a_data)
  );

  route_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .CLK         (CLK),
    .RST         (RST),
    .push_i      (push_b),
    .push_data_i (in_data),
    .full_o      (full_b),
    .pop_i       (pop_b),
    .empty_o     (empty_b),
    .head_o      (b_data)
  );

`ifdef DATA_ROUTE_STATS_EN
  logic [STAT_W-1:0] cnt_a_q, cnt_a_d;
  logic [STAT_W-1:0] cnt_b_q, cnt_b_d;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (pop_a) cnt_a_d = cnt_a_q + 1'b1;
    if (pop_b) cnt_b_d = cnt_b_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

  // A stalled producer must hold its word and destination until accepted.
  a_in_hold: assert property (@(posedge CLK) disable iff (RST)
    (in_valid && !in_ready) |=> (!in_valid || ($stable(in_data) && $stable(in_sel))));

endmodule

// File: tb/tb_data_route.sv
// tb/tb_data_route.sv - scoreboard bench for data_route
module tb_data_route;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sel = 1'b0;
  logic [31:0] in_data = '0;
  logic        a_valid, b_valid;
  logic        a_ready = 1'b0;
  logic        b_ready = 1'b0;
  logic [31:0] a_data, b_data;
`ifdef DATA_ROUTE_STATS_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int vectors = 0;
  int miscompares = 0;
  int pops_a = 0;
  int pops_b = 0;
  int mcnt_a = 0;
  int mcnt_b = 0;
  bit rand_a = 1'b0;
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];

  data_route dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data)
`ifdef DATA_ROUTE_STATS_EN
    ,
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
`endif
  );

  always #5 CLK = ~CLK;

  // Scoreboard: inputs are stable from posedge+1 to the next posedge, so the
  // negedge view predicts exactly which handshakes complete at the next edge.
  always @(negedge CLK) begin
    logic [31:0] e;
    if (RST) begin
      exp_a.delete();
      exp_b.delete();
      mcnt_a = 0;
      mcnt_b = 0;
    end else begin
      if (in_valid && in_ready) begin
        if (in_sel) exp_b.push_back(in_data);
        else        exp_a.push_back(in_data);
      end
      if (a_valid && a_ready) begin
        vectors++;
        if (exp_a.size() == 0) begin
          miscompares++;
          $display("FAIL a_unexpected_word: got %h want none", a_data);
        end else begin
          e = exp_a.pop_front();
          if (a_data !== e) begin
            miscompares++;
            $display("FAIL a_data_order: got %h want %h", a_data, e);
          end
        end
        pops_a++;
        mcnt_a++;
      end
      if (b_valid && b_ready) begin
        vectors++;
        if (exp_b.size() == 0) begin
          miscompares++;
          $display("FAIL b_unexpected_word: got %h want none", b_data);
        end else begin
          e = exp_b.pop_front();
          if (b_data !== e) begin
            miscompares++;
            $display("FAIL b_data_order: got %h want %h", b_data, e);
          end
        end
        pops_b++;
        mcnt_b++;
      end
    end
  end

  always begin
    @(posedge CLK);
    #1;
    if (rand_a) a_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents a word and holds it until it is accepted; leaves in_valid high.
  task automatic send(input logic sel, input logic [31:0] d);
    int n = 0;
    in_sel   = sel;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got in_ready=%b want 1", in_ready);
    end
    tick();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d/%0d words left want 0/0", exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    vectors += 4;
    if (a_valid !== 1'b0) begin miscompares++; $display("FAIL reset_a_valid: got %b want 0", a_valid); end
    if (b_valid !== 1'b0) begin miscompares++; $display("FAIL reset_b_valid: got %b want 0", b_valid); end
    in_sel = 1'b0; #1;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_a: got %b want 1", in_ready); end
    in_sel = 1'b1; #1;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_b: got %b want 1", in_ready); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_single_route();
    a_ready = 1'b0;
    send(1'b0, 32'hDEADBEEF);
    in_valid = 1'b0;
    vectors += 3;
    if (a_valid !== 1'b1) begin miscompares++; $display("FAIL single_a_valid: got %b want 1", a_valid); end
    if (a_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_a_data: got %h want deadbeef", a_data); end
    if (b_valid !== 1'b0) begin miscompares++; $display("FAIL single_b_valid: got %b want 0", b_valid); end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    vectors++;
    if (a_valid !== 1'b0) begin miscompares++; $display("FAIL single_a_popped: got %b want 0", a_valid); end
  endtask

  task automatic test_fill_block();
    a_ready = 1'b0;
    b_ready = 1'b0;
    send(1'b0, 32'h1);
    send(1'b0, 32'h2);
    in_valid = 1'b0;
    vectors += 2;
    in_sel = 1'b0; #1;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready_a: got %b want 0", in_ready); end
    in_sel = 1'b1; #1;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL full_in_ready_b: got %b want 1", in_ready); end
    in_sel = 1'b0;
    in_data = 32'h4;
    in_valid = 1'b1;
    tick();
    tick();
    vectors += 2;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL held_in_ready: got %b want 0", in_ready); end
    if (a_data !== 32'h1) begin miscompares++; $display("FAIL held_a_head: got %h want 00000001", a_data); end
    in_valid = 1'b0;
    tick();
    send(1'b1, 32'h3);
    in_valid = 1'b0;
    vectors += 2;
    if (b_valid !== 1'b1) begin miscompares++; $display("FAIL block_b_valid: got %b want 1", b_valid); end
    if (b_data !== 32'h3) begin miscompares++; $display("FAIL block_b_data: got %h want 00000003", b_data); end
    a_ready = 1'b1;
    b_ready = 1'b1;
    wait_drain(20);
    a_ready = 1'b0;
    b_ready = 1'b0;
  endtask

  task automatic test_order_wrap();
    int start = pops_a;
    rand_a = 1'b1;
    for (int i = 0; i < 16; i++) send(1'b0, 32'h10 + 32'(i));
    in_valid = 1'b0;
    rand_a = 1'b0;
    a_ready = 1'b1;
    wait_drain(100);
    a_ready = 1'b0;
    vectors += 2;
    if (pops_a - start !== 16) begin miscompares++; $display("FAIL wrap_count: got %0d want 16", pops_a - start); end
    if (a_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty: got %b want 0", a_valid); end
  endtask

  task automatic test_simultaneous();
    a_ready = 1'b0;
    send(1'b0, 32'h100);
    in_valid = 1'b0;
    in_data = 32'h200;
    in_valid = 1'b1;
    a_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL simul_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    a_ready = 1'b0;
    vectors += 2;
    if (a_valid !== 1'b1) begin miscompares++; $display("FAIL simul_a_valid: got %b want 1", a_valid); end
    if (a_data !== 32'h200) begin miscompares++; $display("FAIL simul_head: got %h want 00000200", a_data); end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    vectors++;
    if (a_valid !== 1'b0) begin miscompares++; $display("FAIL simul_count_one: got %b want 0", a_valid); end
  endtask

  task automatic test_back_to_back();
    a_ready = 1'b1;
    b_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(1'(i % 2), 32'h300 + 32'(i));
    in_valid = 1'b0;
    wait_drain(20);
    a_ready = 1'b0;
    b_ready = 1'b0;
`ifdef DATA_ROUTE_STATS_EN
    vectors += 2;
    if (cnt_a !== 16'(mcnt_a)) begin miscompares++; $display("FAIL stats_cnt_a: got %0d want %0d", cnt_a, mcnt_a); end
    if (cnt_b !== 16'(mcnt_b)) begin miscompares++; $display("FAIL stats_cnt_b: got %0d want %0d", cnt_b, mcnt_b); end
`endif
  endtask

  task automatic test_reset_mid();
    a_ready = 1'b0;
    b_ready = 1'b0;
    send(1'b0, 32'hA1);
    send(1'b0, 32'hA2);
    send(1'b1, 32'hB1);
    RST = 1'b1;
    in_sel = 1'b1;
    in_data = 32'hB2;
    in_valid = 1'b1;
    a_ready = 1'b1;
    b_ready = 1'b1;
    tick();
    RST = 1'b0;
    in_valid = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    vectors += 4;
    if (a_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_a_valid: got %b want 0", a_valid); end
    if (b_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_b_valid: got %b want 0", b_valid); end
    in_sel = 1'b0; #1;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready_a: got %b want 1", in_ready); end
    in_sel = 1'b1; #1;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready_b: got %b want 1", in_ready); end
`ifdef DATA_ROUTE_STATS_EN
    vectors += 2;
    if (cnt_a !== 16'h0) begin miscompares++; $display("FAIL midrst_cnt_a: got %0d want 0", cnt_a); end
    if (cnt_b !== 16'h0) begin miscompares++; $display("FAIL midrst_cnt_b: got %0d want 0", cnt_b); end
`endif
    send(1'b0, 32'hC1);
    in_valid = 1'b0;
    vectors++;
    if (a_data !== 32'hC1) begin miscompares++; $display("FAIL midrst_fresh_head: got %h want 000000c1", a_data); end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    vectors++;
    if (a_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_drained: got %b want 0", a_valid); end
`ifdef DATA_ROUTE_STATS_EN
    vectors++;
    if (cnt_a !== 16'h1) begin miscompares++; $display("FAIL midrst_cnt_a_one: got %0d want 1", cnt_a); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_route();
    test_fill_block();
    test_order_wrap();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
